// File: rtl/bictr_seq_pkg.sv
// Shared opcodes and FSM state encoding for the up/down counter command sequencer.
package bictr_seq_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_UP   = 2'b01;
  localparam logic [OP_W-1:0] OP_DOWN = 2'b10;
  localparam logic [OP_W-1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // UP and DOWN enable the counter; HOLD only occupies the sequencer.
  function automatic logic op_counts(input logic [OP_W-1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/bictr_seq_shadow.sv
// Shadow model of the driven counter; flags (sticky) any divergence of cnt_q once a preset is seen.
module bictr_seq_shadow
  import bictr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             cen,
  input  logic             count_up_dwn,
  input  logic [WIDTH-1:0] data_preset,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             mismatch
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             armed_q, armed_d;
  logic             mismatch_q, mismatch_d;

  // Track what the counter should hold after this edge; compare only once a known value exists.
  always_comb begin
    shadow_d   = shadow_q;
    armed_d    = armed_q | load;
    mismatch_d = mismatch_q | (armed_q & (cnt_q != shadow_q));
    if (load) begin
      shadow_d = data_preset;
    end else if (cen) begin
      shadow_d = count_up_dwn ? (shadow_q + WIDTH'(1)) : (shadow_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      armed_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      armed_q    <= armed_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;

endmodule

// File: rtl/bictr_seq_ctrl.sv
// Command sequencer driving the preset up/down counter controls for exact cycle counts.
// Optional shadow checking of cnt_q is built when BICTR_SEQ_SHADOW_CHECK_EN is defined.
module bictr_seq_ctrl
  import bictr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             busy,
  output logic             done,
  output logic             cen,
  output logic             count_up_dwn,
  output logic             load,
  output logic [WIDTH-1:0] data_preset,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             mismatch
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cen_q, cen_d;
  logic             cud_q, cud_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] dp_q, dp_d;

  logic accept_c;
  logic last_cycle_c;

  assign accept_c     = cmd_valid & ready_q;
  assign last_cycle_c = (state_q == S_LOAD) || ((state_q == S_RUN) && (rem_q == '0));

  // Next state and next registered outputs; a command accepted in a last cycle chains with no gap.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cen_d   = cen_q;
    cud_d   = cud_q;
    load_d  = 1'b0;
    dp_d    = '0;
    done_d  = 1'b0;

    if ((state_q == S_RUN) && (rem_q != '0)) begin
      rem_d = rem_q - WIDTH'(1);
    end

    if (last_cycle_c) begin
      state_d = S_IDLE;
      cen_d   = 1'b0;
      cud_d   = 1'b0;
      done_d  = 1'b1;
    end

    if (accept_c) begin
      if (cmd_op == OP_LOAD) begin
        state_d = S_LOAD;
        rem_d   = '0;
        load_d  = 1'b1;
        cen_d   = 1'b1;
        cud_d   = 1'b0;
        dp_d    = cmd_arg;
      end else if (cmd_arg == '0) begin
        // Zero-length command: completes immediately without touching the counter.
        state_d = S_IDLE;
        rem_d   = '0;
        cen_d   = 1'b0;
        cud_d   = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        rem_d   = cmd_arg - WIDTH'(1);
        cen_d   = op_counts(cmd_op);
        cud_d   = (cmd_op == OP_UP);
      end
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d != S_RUN) || (rem_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b0;
      cud_q   <= 1'b0;
      load_q  <= 1'b0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cen_q   <= cen_d;
      cud_q   <= cud_d;
      load_q  <= load_d;
      dp_q    <= dp_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cen          = cen_q;
  assign count_up_dwn = cud_q;
  assign load         = load_q;
  assign data_preset  = dp_q;

`ifdef BICTR_SEQ_SHADOW_CHECK_EN
  bictr_seq_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .load         (load_q),
    .cen          (cen_q),
    .count_up_dwn (cud_q),
    .data_preset  (dp_q),
    .cnt_q        (cnt_q),
    .mismatch     (mismatch)
  );
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_bictr_seq_ctrl.sv
// Bench for bictr_seq_ctrl driving a behavioural preset up/down counter.
module tb_bictr_seq_ctrl;

  localparam int unsigned W = 8;
  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_UP   = 2'b01;
  localparam logic [1:0] T_DOWN = 2'b10;
  localparam logic [1:0] T_HOLD = 2'b11;
`ifdef BICTR_SEQ_SHADOW_CHECK_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic         cmd_ready, busy, done, cen, count_up_dwn, load, mismatch;
  logic [W-1:0] data_preset;
  logic [W-1:0] cnt = '0;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  logic [W-1:0] cnt_q;

  assign cnt_q = force_en ? force_val : cnt;

  always #5 clk = ~clk;

  // Counter under control: load has priority over counting.
  always @(posedge clk) begin
    if (load) cnt <= data_preset;
    else if (cen) cnt <= count_up_dwn ? cnt + 8'd1 : cnt - 8'd1;
  end

  bictr_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .busy(busy), .done(done), .cen(cen),
    .count_up_dwn(count_up_dwn), .load(load), .data_preset(data_preset),
    .cnt_q(cnt_q), .mismatch(mismatch)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] outv();
    return {cmd_ready, busy, done, cen, count_up_dwn, load, data_preset, mismatch};
  endfunction

  function automatic logic [14:0] mk(input logic rdy, input logic bsy, input logic dn,
                                     input logic ce, input logic up, input logic ld,
                                     input logic [7:0] dp, input logic mm);
    return {rdy, bsy, dn, ce, up, ld, dp, mm};
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    int n = 0;
    while (!cmd_ready && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    int         act_n;
    int         cen_n;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic       cen;
    logic       up;
    logic       load;
    logic [7:0] dp;
    logic       last;
  } rec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    rec_t q[$];
    rec_t cur;
    rec_t r;
    bit   cur_v, exp_done, pend, acc, nd, drained, seen;
    logic [1:0] p_op;
    logic [7:0] p_arg, exp_cnt, frozen;
    int lat, bn, cn, dn, gap;

    tbl[0]  = '{T_LOAD, 8'd13,  1,   1,   8'd13};
    tbl[1]  = '{T_UP,   8'd20,  20,  20,  8'd33};
    tbl[2]  = '{T_DOWN, 8'd3,   3,   3,   8'd30};
    tbl[3]  = '{T_HOLD, 8'd5,   5,   0,   8'd30};
    tbl[4]  = '{T_UP,   8'd0,   0,   0,   8'd30};
    tbl[5]  = '{T_LOAD, 8'd1,   1,   1,   8'd1};
    tbl[6]  = '{T_DOWN, 8'd3,   3,   3,   8'd254};
    tbl[7]  = '{T_LOAD, 8'd250, 1,   1,   8'd250};
    tbl[8]  = '{T_UP,   8'd10,  10,  10,  8'd4};
    tbl[9]  = '{T_HOLD, 8'd0,   0,   0,   8'd4};
    tbl[10] = '{T_DOWN, 8'd255, 255, 255, 8'd5};

    // Power-on reset
    step();
    step();
    chk("reset_state", 32'(outv()), 32'(mk(1, 0, 0, 0, 0, 0, 8'd0, 0)));
    rst = 1'b0;
    step();
    chk("idle_after_reset", 32'(outv()), 32'(mk(1, 0, 0, 0, 0, 0, 8'd0, 0)));

    // Table: one command from idle, measure latency to done, active/enable cycles, final count
    for (int e = 0; e < 11; e++) begin
      send(tbl[e].op, tbl[e].arg);
      bn = 0; cn = 0; lat = -1;
      for (int c = 0; c < 400; c++) begin
        if (done) begin
          lat = c;
          break;
        end
        bn += int'(busy);
        cn += int'(cen);
        step();
      end
      chk($sformatf("tbl%0d_latency", e), 32'(lat), 32'(tbl[e].act_n));
      chk($sformatf("tbl%0d_busy_cycles", e), 32'(bn), 32'(tbl[e].act_n));
      chk($sformatf("tbl%0d_cen_cycles", e), 32'(cn), 32'(tbl[e].cen_n));
      chk($sformatf("tbl%0d_counter", e), 32'(cnt), 32'(tbl[e].cnt));
      step();
      chk($sformatf("tbl%0d_done_single", e), 32'(done), 32'd0);
    end

    // Chained LOAD 0 -> UP 20 with cmd_valid held throughout
    cmd_op = T_LOAD; cmd_arg = 8'd0; cmd_valid = 1'b1;
    step();
    chk("chain_load_phase", 32'({load, cen, data_preset, cmd_ready}), 32'({1'b1, 1'b1, 8'd0, 1'b1}));
    cmd_op = T_UP; cmd_arg = 8'd20;
    step();
    cmd_valid = 1'b0;
    chk("chain_first_run", 32'(outv()), 32'(mk(0, 1, 1, 1, 1, 0, 8'd0, 0)));
    cn = 1; dn = 1; gap = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done) begin
        dn++;
        seen = 1;
        break;
      end
      cn += int'(cen & count_up_dwn);
      gap += int'(!busy);
    end
    chk("chain_done_seen", 32'(seen), 32'd1);
    chk("chain_up_cycles", 32'(cn), 32'd20);
    chk("chain_done_pulses", 32'(dn), 32'd2);
    chk("chain_no_gap", 32'(gap), 32'd0);
    chk("chain_counter", 32'(cnt), 32'd20);
    step();

    // Randomized traffic vs. a per-command trace model
    q.delete();
    cur = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    cur_v = 0; exp_done = 0; pend = 0; drained = 0;
    p_op = 2'b00; p_arg = 8'd0;
    exp_cnt = cnt;
    for (int i = 0; i < 3000; i++) begin
      chk("rand_outputs", 32'(outv()),
          32'(mk(!cur_v || cur.last, cur_v, exp_done, cur_v & cur.cen, cur_v & cur.up,
                 cur_v & cur.load, cur_v ? cur.dp : 8'd0, 1'b0)));
      chk("rand_counter", 32'(cnt), 32'(exp_cnt));
      if (i >= 1600 && !pend && !cur_v && !exp_done) begin
        drained = 1;
        break;
      end
      if (!pend && i < 1600 && $urandom_range(0, 2) == 0) begin
        pend  = 1;
        p_op  = 2'($urandom_range(0, 3));
        p_arg = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
      end
      cmd_valid = pend;
      cmd_op    = p_op;
      cmd_arg   = p_arg;
      acc = pend && (!cur_v || cur.last);
      nd  = (cur_v && cur.last) || (acc && p_op != T_LOAD && p_arg == 8'd0);
      if (acc) begin
        if (p_op == T_LOAD) begin
          r = '{1'b1, 1'b0, 1'b1, p_arg, 1'b1};
          q.push_back(r);
        end else begin
          for (int k = 0; k < int'(p_arg); k++) begin
            r = '{p_op != T_HOLD, p_op == T_UP, 1'b0, 8'd0, k == int'(p_arg) - 1};
            q.push_back(r);
          end
        end
        pend = 0;
      end
      if (cur_v) begin
        if (cur.load) exp_cnt = cur.dp;
        else if (cur.cen) exp_cnt = cur.up ? exp_cnt + 8'd1 : exp_cnt - 8'd1;
      end
      step();
      cur_v = (q.size() > 0);
      if (cur_v) cur = q.pop_front();
      exp_done = nd;
    end
    cmd_valid = 1'b0;
    chk("rand_drained", 32'(drained), 32'd1);

    // Reset in the middle of UP 50: command dropped, no done, counter frozen
    send(T_UP, 8'd50);
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    step();
    frozen = cnt;
    step();
    rst = 1'b0;
    chk("midreset_idle", 32'(outv()), 32'(mk(1, 0, 0, 0, 0, 0, 8'd0, 0)));
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      dn += int'(done);
    end
    chk("midreset_no_done", 32'(dn), 32'd0);
    chk("midreset_counter_frozen", 32'(cnt), 32'(frozen));

    // Shadow check: corrupt cnt_q for one cycle after LOAD 250
    send(T_LOAD, 8'd250);
    step();
    chk("shadow_pre_force", 32'({cnt, mismatch}), 32'({8'd250, 1'b0}));
    force_en = 1'b1; force_val = 8'd7;
    step();
    force_en = 1'b0;
    chk("shadow_mismatch_set", 32'(mismatch), 32'(SHADOW));
    for (int c = 0; c < 3; c++) step();
    chk("shadow_mismatch_sticky", 32'(mismatch), 32'(SHADOW));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("shadow_cleared_by_reset", 32'(outv()), 32'(mk(1, 0, 0, 0, 0, 0, 8'd0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
